// File: rtl/hazard_unit.sv
// Stall/flush hazard detector for the 5-stage MIPS pipeline: load-use and branch-operand
// interlocks, multiply/divide busy tracking and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_uses_Rs,
  input  logic             ID_uses_Rt,
  input  logic             ID_is_branch,
  input  logic             ID_mdu_start,
  input  logic             ID_reads_hilo,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ID_EX_memread,
  input  logic             ID_EX_regwrite,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_Mem_memread,
  input  logic [4:0]       EX_Mem_Rd,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MCW = $clog2(MDU_LATENCY + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // A producer register collides with the ID instruction only on a real read; $zero never does.
  function automatic logic reg_match(
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic       uses_rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (dst != 5'd0) && ((uses_rs && (dst == rs)) || (uses_rt && (dst == rt)));
  endfunction

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [MCW-1:0]   cnt_r;
  logic [MCW-1:0]   cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             load_use_s;
  logic             branch_haz_s;
  logic             mdu_haz_s;
  logic             stall_s;
  logic             redirect_s;

  // Hazard terms for the instruction currently in ID.
  always_comb begin
    load_use_s   = 1'b0;
    branch_haz_s = 1'b0;
    mdu_haz_s    = 1'b0;
    load_use_s   = ID_EX_memread && reg_match(ID_EX_Rt, ID_Rs, ID_uses_Rs, ID_Rt, ID_uses_Rt);
    branch_haz_s = ID_is_branch &&
                   ((ID_EX_regwrite && reg_match(ID_EX_Rd, ID_Rs, ID_uses_Rs, ID_Rt, ID_uses_Rt)) ||
                    (EX_Mem_memread && reg_match(EX_Mem_Rd, ID_Rs, ID_uses_Rs, ID_Rt, ID_uses_Rt)));
    mdu_haz_s    = (state_r == BUSY) && (ID_reads_hilo || ID_mdu_start);
    stall_s      = load_use_s | branch_haz_s | mdu_haz_s;
    redirect_s   = branch_taken | jump;
  end

  // Pipeline control; a redirect seen while stalled is dropped and re-evaluated later.
  always_comb begin
    PC_write     = ~stall_s;
    IF_ID_write  = ~stall_s;
    ID_EX_bubble = stall_s;
    if (stall_s) begin
      IF_ID_flush = 1'b0;
    end else begin
      IF_ID_flush = redirect_s;
    end
  end

  // MDU next state: accept only when the mult/div actually leaves ID.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (ID_mdu_start && !stall_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = MCW'(MDU_LATENCY);
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {MCW{1'b0}};
        end
      end
      BUSY: begin
        if (cnt_r <= MCW'(1)) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {MCW{1'b0}};
        end else begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = cnt_r - MCW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {MCW{1'b0}};
      end
    endcase
  end

  // MDU state register; reset aborts any pending HI/LO window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {MCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating stall counter, one count per stalled cycle regardless of cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign mdu_busy     = (state_r == BUSY);
  assign stall_cycles = stall_cnt_r;

  hazard_unit_checker #(
    .MDU_LATENCY(MDU_LATENCY),
    .MCW        (MCW)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall_s),
    .pc_write    (PC_write),
    .bubble      (ID_EX_bubble),
    .flush       (IF_ID_flush),
    .mdu_busy    (mdu_busy),
    .cnt         (cnt_r)
  );

endmodule

// Structural invariants of the hazard unit.
module hazard_unit_checker #(
  parameter int MDU_LATENCY = 4,
  parameter int MCW         = 3
) (
  input logic           clk,
  input logic           rst,
  input logic           stall,
  input logic           pc_write,
  input logic           bubble,
  input logic           flush,
  input logic           mdu_busy,
  input logic [MCW-1:0] cnt
);

  a_flush_not_stalled: assert property (@(posedge clk) disable iff (rst) flush |-> !stall);
  a_bubble_vs_write:   assert property (@(posedge clk) disable iff (rst) pc_write != bubble);
  a_cnt_range:         assert property (@(posedge clk) disable iff (rst) cnt <= MCW'(MDU_LATENCY));
  a_busy_has_cnt:      assert property (@(posedge clk) disable iff (rst) mdu_busy |-> (cnt != {MCW{1'b0}}));

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model expectations, monitor pops and compares.
module tb_hazard_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    ID_Rs, ID_Rt, ID_EX_Rt, ID_EX_Rd, EX_Mem_Rd;
  logic          ID_uses_Rs, ID_uses_Rt, ID_is_branch, ID_mdu_start, ID_reads_hilo;
  logic          branch_taken, jump, ID_EX_memread, ID_EX_regwrite, EX_Mem_memread;
  logic          PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, mdu_busy;
  logic [CW-1:0] stall_cycles;

  hazard_unit #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rs(ID_uses_Rs), .ID_uses_Rt(ID_uses_Rt),
    .ID_is_branch(ID_is_branch), .ID_mdu_start(ID_mdu_start), .ID_reads_hilo(ID_reads_hilo),
    .branch_taken(branch_taken), .jump(jump),
    .ID_EX_memread(ID_EX_memread), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .EX_Mem_memread(EX_Mem_memread), .EX_Mem_Rd(EX_Mem_Rd),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic          pcw;
    logic          ifw;
    logic          bub;
    logic          fl;
    logic          busy;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: cycle index and the absolute window during which HI/LO is pending.
  int cyc      = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;
  int stalls   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hits(input logic [4:0] r);
    return (r != 5'd0) && ((ID_uses_Rs && r == ID_Rs) || (ID_uses_Rt && r == ID_Rt));
  endfunction

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_uses_Rs = 1'b0; ID_uses_Rt = 1'b0;
    ID_is_branch = 1'b0; ID_mdu_start = 1'b0; ID_reads_hilo = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    ID_EX_memread = 1'b0; ID_EX_regwrite = 1'b0; ID_EX_Rt = 5'd0; ID_EX_Rd = 5'd0;
    EX_Mem_memread = 1'b0; EX_Mem_Rd = 5'd0;
  endtask

  // Inputs are already applied; predict this cycle, then advance one clock.
  task automatic step();
    exp_t e;
    bit busy, lu, bh, mh, st;
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    lu   = ID_EX_memread && hits(ID_EX_Rt);
    bh   = ID_is_branch && ((ID_EX_regwrite && hits(ID_EX_Rd)) || (EX_Mem_memread && hits(EX_Mem_Rd)));
    mh   = busy && (ID_reads_hilo || ID_mdu_start);
    st   = lu || bh || mh;
    e.pcw  = !st;
    e.ifw  = !st;
    e.bub  = st;
    e.fl   = (branch_taken || jump) && !st;
    e.busy = busy;
    e.cnt  = CW'(stalls);
    e.cyc  = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      busy_lo = 1;
      busy_hi = 0;
      stalls  = 0;
    end else begin
      if (st && stalls < SAT) stalls = stalls + 1;
      if (!busy && ID_mdu_start && !st) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + LAT;
      end
    end
    cyc = cyc + 1;
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("PC_write",     {31'd0, PC_write},     {31'd0, e.pcw});
      chk("IF_ID_write",  {31'd0, IF_ID_write},  {31'd0, e.ifw});
      chk("ID_EX_bubble", {31'd0, ID_EX_bubble}, {31'd0, e.bub});
      chk("IF_ID_flush",  {31'd0, IF_ID_flush},  {31'd0, e.fl});
      chk("mdu_busy",     {31'd0, mdu_busy},     {31'd0, e.busy});
      chk("stall_cycles", {28'd0, stall_cycles}, {28'd0, e.cnt});
    end
  end

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // load-use on $t0
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_Rt = 5'd8; ID_Rs = 5'd8; ID_uses_Rs = 1'b1;
    step();
    chk("lu_count", {28'd0, stall_cycles}, 32'd1);
    ID_EX_memread = 1'b0; EX_Mem_memread = 1'b1; EX_Mem_Rd = 5'd8;
    step();

    // $zero and unused Rt never match
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_Rt = 5'd0; ID_Rs = 5'd0; ID_uses_Rs = 1'b1;
    step();
    ID_EX_Rt = 5'd9; ID_Rt = 5'd9; ID_uses_Rt = 1'b0;
    step();

    // branch after load: two stall cycles
    clear_inputs();
    ID_is_branch = 1'b1; ID_Rs = 5'd9; ID_uses_Rs = 1'b1;
    ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_Rt = 5'd9; ID_EX_Rd = 5'd9;
    step();
    ID_EX_memread = 1'b0; ID_EX_regwrite = 1'b0; EX_Mem_memread = 1'b1; EX_Mem_Rd = 5'd9;
    step();
    EX_Mem_memread = 1'b0;
    step();
    chk("brload_count", {28'd0, stall_cycles}, 32'd3);

    // branch after ALU producer: one stall cycle
    clear_inputs();
    ID_is_branch = 1'b1; ID_Rt = 5'd5; ID_uses_Rt = 1'b1;
    ID_EX_regwrite = 1'b1; ID_EX_Rd = 5'd5;
    step();
    ID_EX_regwrite = 1'b0; EX_Mem_Rd = 5'd5;
    step();

    // mult accepted, mflo waits until HI/LO settles
    clear_inputs();
    ID_mdu_start = 1'b1;
    step();
    ID_mdu_start = 1'b0;
    step();
    ID_reads_hilo = 1'b1;
    repeat (4) step();
    chk("mdu_count", {28'd0, stall_cycles}, 32'd7);

    // stall beats redirect, redirect taken once stall clears
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_Rt = 5'd8; ID_Rs = 5'd8; ID_uses_Rs = 1'b1; branch_taken = 1'b1;
    step();
    ID_EX_memread = 1'b0;
    step();

    // saturation, then reset in the middle of a busy window
    ID_EX_memread = 1'b1; branch_taken = 1'b0;
    repeat (20) step();
    chk("sat_count", {28'd0, stall_cycles}, SAT);
    clear_inputs();
    ID_mdu_start = 1'b1;
    step();
    ID_mdu_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy",  {31'd0, mdu_busy}, 32'd0);
    chk("rst_count", {28'd0, stall_cycles}, 32'd0);

    // randomized traffic biased toward register collisions
    for (int i = 0; i < 600; i++) begin
      ID_Rs          = rreg();
      ID_Rt          = rreg();
      ID_uses_Rs     = 1'($urandom_range(0, 1));
      ID_uses_Rt     = 1'($urandom_range(0, 1));
      ID_is_branch   = ($urandom_range(0, 2) == 0);
      ID_mdu_start   = ($urandom_range(0, 5) == 0);
      ID_reads_hilo  = ($urandom_range(0, 4) == 0);
      branch_taken   = ($urandom_range(0, 3) == 0);
      jump           = ($urandom_range(0, 7) == 0);
      ID_EX_memread  = ($urandom_range(0, 2) == 0);
      ID_EX_regwrite = 1'($urandom_range(0, 1));
      ID_EX_Rt       = rreg();
      ID_EX_Rd       = rreg();
      EX_Mem_memread = ($urandom_range(0, 2) == 0);
      EX_Mem_Rd      = rreg();
      rst            = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    clear_inputs();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detector for the 5-stage MIPS core: the stall/flush side of the operand-delivery problem. The forwarding unit resolves operands by bypassing values; this block handles the cases bypassing cannot cover. It detects load-use and branch-operand hazards for the instruction in ID and tracks the multi-cycle multiply/divide unit. From those it drives PC / IF_ID write enables, the ID_EX bubble and the IF_ID flush. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MDU_LATENCY, 4, cycles HI/LO are busy after a mult/div is accepted (must be ≥1)
- CNT_W, 32, width of stall_cycles

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- ID_Rs, ID_Rt  input  5  source registers of the instruction in ID
- ID_uses_Rs, ID_uses_Rt  input  1  ID instruction actually reads Rs / Rt
- ID_is_branch  input  1  ID instruction is beq/bne (compared in ID)
- ID_mdu_start  input  1  ID instruction is mult/multu/div/divu
- ID_reads_hilo  input  1  ID instruction is mfhi/mflo
- branch_taken, jump  input  1  redirect resolved in ID this cycle
- ID_EX_memread, ID_EX_regwrite  input  1  control bits of the instruction in EX
- ID_EX_Rt  input  5  load destination field in EX
- ID_EX_Rd  input  5  final destination of EX, after the RegDst mux
- EX_Mem_memread  input  1  MEM-stage instruction is a load
- EX_Mem_Rd  input  5  MEM-stage destination
- PC_write, IF_ID_write  output  1  write enables (low = hold)
- ID_EX_bubble  output  1  zero control bits into ID_EX
- IF_ID_flush  output  1  squash the fetched instruction
- mdu_busy  output  1  HI/LO result pending
- stall_cycles  output  CNT_W  saturating count of stalled cycles

## Operation
A register "matches" when it equals ID_Rs with ID_uses_Rs=1, or equals ID_Rt with ID_uses_Rt=1. Register 0 never matches.
- load_use = ID_EX_memread && ID_EX_Rt matches.
- branch_haz = ID_is_branch && ((ID_EX_regwrite && ID_EX_Rd matches) || (EX_Mem_memread && EX_Mem_Rd matches)).
- mdu_haz = mdu_busy && (ID_reads_hilo || ID_mdu_start).
- stall = load_use | branch_haz | mdu_haz.

Combinational outputs:
- PC_write = IF_ID_write = ~stall.
- ID_EX_bubble = stall.
- IF_ID_flush = (branch_taken | jump) && ~stall. A redirect is ignored while stalled and is re-evaluated on the cycle after the stall clears.

MDU FSM, with states IDLE and BUSY and down-counter cnt of width clog2(MDU_LATENCY+1):
- IDLE: when ID_mdu_start && ~stall (instruction accepted), set cnt <= MDU_LATENCY and go to BUSY.
- BUSY: cnt decrements every cycle. When cnt==1, go to IDLE next edge with cnt <= 0.
- A second mult/div in ID while BUSY stalls and is accepted in the first IDLE cycle. No back-to-back overlap.
- mdu_busy = (state==BUSY), registered.

Performance counter: stall_cycles increments on every clock edge where stall=1 and rst=0. It holds at all-ones (saturates) and never wraps.

## Timing
- Reset, sampled on the clk edge with rst=1: state=IDLE, cnt=0, mdu_busy=0, stall_cycles=0.
- Reset mid-BUSY aborts the pending HI/LO window. mdu_busy=0 the cycle after the reset edge.
- Combinational outputs follow inputs in the same cycle, reset included. They equal PC_write=1, IF_ID_write=1, ID_EX_bubble=0 whenever no hazard inputs are active.
- Load-use stalls last exactly 1 cycle: the load advances to MEM and load_use drops.
- Branch after ALU producer: 1 stall cycle, then forwarding from MEM.
- Branch after load: 2 stall cycles, via the ID_EX term and then the EX_Mem_memread term.
- mdu_busy rises the cycle after acceptance and stays high for exactly MDU_LATENCY cycles.
- Simultaneous hazards: a single stall is produced, counted once per cycle.
- Simultaneous stall and redirect: the stall wins and the flush is suppressed.

## Test plan
- Load-use: lw $t0 in EX (ID_EX_memread=1, ID_EX_Rt=8), add in ID with ID_Rs=8 -> PC_write=0, ID_EX_bubble=1 for 1 cycle; stall_cycles=1.
- $zero: same as the load-use case but ID_EX_Rt=0 and ID_Rs=0 -> no stall. Also ID_uses_Rt=0 with a matching ID_Rt -> no stall.
- Branch after load: beq in ID reads reg 9. Cycle 1: lw in EX writes 9. Cycle 2: the load moves to MEM (EX_Mem_memread=1, EX_Mem_Rd=9). Required: stall in both cycles, clear on cycle 3, stall_cycles=2.
- MDU with MDU_LATENCY=4: mult accepted at cycle 0 -> mdu_busy=1 on cycles 1-4. mflo in ID on cycle 2 -> stall on cycles 2-4, released on cycle 5.
- Stall plus redirect: branch_taken=1 while load_use=1 -> IF_ID_flush=0. The next cycle, with no stall and branch_taken=1 -> IF_ID_flush=1.
- Saturation and reset: with CNT_W=4, force stall for 20 cycles -> stall_cycles=15. Assert rst during BUSY -> mdu_busy=0 and stall_cycles=0 after the edge.
